// File: rtl/fifo_arbiter_if.sv
// Client and FIFO-side signal bundle for fifo_arbiter.
// The master modport is the arbiter view; the slave modport is the clients plus FIFO.
interface fifo_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [1:0]            wr_req;
   logic [DATA_WIDTH-1:0] wr_data0;
   logic [DATA_WIDTH-1:0] wr_data1;
   logic [1:0]            wr_done;
   logic [1:0]            wr_fail;
   logic [1:0]            rd_req;
   logic [1:0]            rd_done;
   logic [1:0]            rd_fail;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  busy;
   logic                  f_wr_en;
   logic                  f_rd_en;
   logic [DATA_WIDTH-1:0] f_din;
   logic [DATA_WIDTH-1:0] f_dout;
   logic                  f_full;
   logic                  f_empty;
   logic                  f_wr_ack;
   logic                  f_wr_err;
   logic                  f_rd_ack;
   logic                  f_rd_err;

   modport master (
      input  wr_req, wr_data0, wr_data1, rd_req,
      input  f_dout, f_full, f_empty, f_wr_ack, f_wr_err, f_rd_ack, f_rd_err,
      output wr_done, wr_fail, rd_done, rd_fail, rd_data, busy,
      output f_wr_en, f_rd_en, f_din
   );

   modport slave (
      output wr_req, wr_data0, wr_data1, rd_req,
      output f_dout, f_full, f_empty, f_wr_ack, f_wr_err, f_rd_ack, f_rd_err,
      input  wr_done, wr_fail, rd_done, rd_fail, rd_data, busy,
      input  f_wr_en, f_rd_en, f_din
   );
endinterface

// File: rtl/fifo_arbiter.sv
// Shares one FIFO between two writers and two readers: arbitrate, pulse the
// FIFO enable once, wait for ack/err (or timeout), then return done/fail.
module fifo_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 4
) (
   input  logic          clk,
   input  logic          reset,
   fifo_arbiter_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic       OP_RD = 1'b0;
   localparam logic       OP_WR = 1'b1;
   localparam logic [3:0] TMO   = 4'(TIMEOUT);

   logic [1:0]            state,     state_nxt;
   logic [3:0]            cnt,       cnt_nxt;
   logic                  op,        op_nxt;
   logic                  idx,       idx_nxt;
   logic                  wr_ptr,    wr_ptr_nxt;
   logic                  rd_ptr,    rd_ptr_nxt;
   logic                  last_op,   last_op_nxt;
   logic                  f_wr_en,   f_wr_en_nxt;
   logic                  f_rd_en,   f_rd_en_nxt;
   logic [DATA_WIDTH-1:0] f_din,     f_din_nxt;
   logic [DATA_WIDTH-1:0] rd_data,   rd_data_nxt;
   logic [1:0]            wr_done,   wr_done_nxt;
   logic [1:0]            wr_fail,   wr_fail_nxt;
   logic [1:0]            rd_done,   rd_done_nxt;
   logic [1:0]            rd_fail,   rd_fail_nxt;
   logic                  busy,      busy_nxt;

   logic [1:0] wr_elig;
   logic [1:0] rd_elig;
   logic       grant_wr;
   logic       grant_rd;
   logic       wr_sel;
   logic       rd_sel;
   logic       ack;
   logic       err;
   logic [1:0] grantee;

   // Status only gates eligibility; a stale status surfaces later as a FIFO error.
   assign wr_elig  = bus.f_full  ? 2'b00 : bus.wr_req;
   assign rd_elig  = bus.f_empty ? 2'b00 : bus.rd_req;
   assign grant_wr = (|wr_elig) && (!(|rd_elig) || (last_op == OP_RD));
   assign grant_rd = (|rd_elig) && !grant_wr;
   assign wr_sel   = wr_elig[wr_ptr] ? wr_ptr : ~wr_ptr;
   assign rd_sel   = rd_elig[rd_ptr] ? rd_ptr : ~rd_ptr;
   assign ack      = (op == OP_WR) ? bus.f_wr_ack : bus.f_rd_ack;
   assign err      = (op == OP_WR) ? bus.f_wr_err : bus.f_rd_err;
   assign grantee  = idx ? 2'b10 : 2'b01;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      op_nxt      = op;
      idx_nxt     = idx;
      wr_ptr_nxt  = wr_ptr;
      rd_ptr_nxt  = rd_ptr;
      last_op_nxt = last_op;
      f_din_nxt   = f_din;
      rd_data_nxt = rd_data;
      f_wr_en_nxt = 1'b0;
      f_rd_en_nxt = 1'b0;
      wr_done_nxt = 2'b00;
      wr_fail_nxt = 2'b00;
      rd_done_nxt = 2'b00;
      rd_fail_nxt = 2'b00;
      busy_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (grant_wr) begin
               op_nxt      = OP_WR;
               idx_nxt     = wr_sel;
               f_din_nxt   = wr_sel ? bus.wr_data1 : bus.wr_data0;
               wr_ptr_nxt  = ~wr_sel;
               last_op_nxt = OP_WR;
               f_wr_en_nxt = 1'b1;
               state_nxt   = ISSUE;
            end else if (grant_rd) begin
               op_nxt      = OP_RD;
               idx_nxt     = rd_sel;
               rd_ptr_nxt  = ~rd_sel;
               last_op_nxt = OP_RD;
               f_rd_en_nxt = 1'b1;
               state_nxt   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = 4'd0;
            state_nxt = WAIT;
         end
         WAIT: begin
            // err beats ack; timeout is reported like an error.
            if (err || (!ack && (cnt + 4'd1 >= TMO))) begin
               if (op == OP_WR) wr_fail_nxt = grantee;
               else             rd_fail_nxt = grantee;
               state_nxt = RESP;
            end else if (ack) begin
               if (op == OP_WR) begin
                  wr_done_nxt = grantee;
               end else begin
                  rd_done_nxt = grantee;
                  rd_data_nxt = bus.f_dout;
               end
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         op      <= OP_RD;
         idx     <= 1'b0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         last_op <= OP_RD;
         f_wr_en <= 1'b0;
         f_rd_en <= 1'b0;
         f_din   <= '0;
         rd_data <= '0;
         wr_done <= 2'b00;
         wr_fail <= 2'b00;
         rd_done <= 2'b00;
         rd_fail <= 2'b00;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         op      <= op_nxt;
         idx     <= idx_nxt;
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         last_op <= last_op_nxt;
         f_wr_en <= f_wr_en_nxt;
         f_rd_en <= f_rd_en_nxt;
         f_din   <= f_din_nxt;
         rd_data <= rd_data_nxt;
         wr_done <= wr_done_nxt;
         wr_fail <= wr_fail_nxt;
         rd_done <= rd_done_nxt;
         rd_fail <= rd_fail_nxt;
         busy    <= busy_nxt;
      end
   end

   assign bus.f_wr_en = f_wr_en;
   assign bus.f_rd_en = f_rd_en;
   assign bus.f_din   = f_din;
   assign bus.rd_data = rd_data;
   assign bus.wr_done = wr_done;
   assign bus.wr_fail = wr_fail;
   assign bus.rd_done = rd_done;
   assign bus.rd_fail = rd_fail;
   assign bus.busy    = busy;
endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Scheduler that shares one 8-entry synchronous FIFO between two write requesters and two read requesters. It arbitrates pending requests and issues at most one single-cycle `f_wr_en`/`f_rd_en` pulse per operation. It waits for the FIFO's ack/err response and returns a done or fail pulse plus read data to the granted requester. It sits between the client logic and the FIFO top-level, replacing direct client access to the FIFO enables.

## Interface
- `DATA_WIDTH`, 32, FIFO data width
- `TIMEOUT`, 4, cycles in WAIT before abandoning an operation (legal 1..15)

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `wr_req`  in  2  write request per requester, level, held until `wr_done`/`wr_fail`
- `wr_data0`, `wr_data1`  in  DATA_WIDTH  write data, stable while request high
- `wr_done`, `wr_fail`  out  2  one-cycle completion pulses, one-hot to granted writer
- `rd_req`  in  2  read request per requester, level
- `rd_done`, `rd_fail`  out  2  one-cycle completion pulses, one-hot to granted reader
- `rd_data`  out  DATA_WIDTH  registered read data, valid with `rd_done`
- `busy`  out  1  high in any state other than IDLE
- `f_wr_en`, `f_rd_en`  out  1  FIFO enables, registered, never both high
- `f_din`  out  DATA_WIDTH  FIFO write data, registered with the grant
- `f_dout`  in  DATA_WIDTH  FIFO read data
- `f_full`, `f_empty`  in  1  FIFO status
- `f_wr_ack`, `f_wr_err`, `f_rd_ack`, `f_rd_err`  in  1  FIFO response, sampled in WAIT

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Encoding is 2-bit binary.
- IDLE: the eligible write set is `wr_req` when `!f_full`, else empty. The eligible read set is `rd_req` when `!f_empty`, else empty.
  - If only one set is non-empty, that type wins.
  - If both are non-empty, the type opposite to `last_op` wins.
  - Within the winning type, a per-type round-robin pointer selects the requester: the preferred one if it is requesting, else the other.
  - On a grant: register the grantee index and type, and load `f_din` from the grantee's data (writes). Flip that type's pointer away from the grantee, set `last_op`, then go to ISSUE.
  - With no grant, stay in IDLE.
- ISSUE: `f_wr_en` or `f_rd_en` is high for exactly this cycle. Next state is WAIT, with the timeout counter cleared.
- WAIT: the response is checked against the granted type only.
  - err → fail for that operation.
  - ack → success. On a read, capture `f_dout` into `rd_data`.
  - ack and err in the same cycle → fail (err wins).
  - Neither → counter+1. When counter reaches `TIMEOUT` → fail.
  - Any outcome goes to RESP.
- RESP: drive the registered done or fail pulse for the grantee bit only. Next state is IDLE.
- A requester that drops its request after the grant still receives its done/fail pulse. The operation is not cancelled.
- Requests are ignored outside IDLE. A request is never granted twice for one assertion, provided the client drops it in the cycle after done/fail.
- Counter is 4 bits and does not wrap (maximum is `TIMEOUT`). Round-robin pointers are 1 bit each.
- Reset values:
  - state IDLE, all pulses 0, `f_wr_en`=`f_rd_en`=0, `busy`=0
  - `f_din`=0, `rd_data`=0
  - both pointers 0, `last_op`=read (so write is preferred first), counter 0
- Reset mid-operation aborts immediately: no done/fail pulse is issued, and the FIFO enables drop asynchronously.

## Timing
- Request high during IDLE cycle T → enable high at T+1 (ISSUE) → response sampled at T+2 (WAIT) → done/fail at T+3 (RESP) → IDLE at T+4.
  - Minimum is 4 cycles per operation, so throughput is at most one operation per 4 cycles.
- Worst case with no response is T+2+`TIMEOUT` for the fail pulse.
- `f_full`/`f_empty` are sampled only in IDLE. A stale status that leads to a FIFO error is reported as fail.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `wr_req`=01 with `wr_data0`=0xA5A5A5A5 and the FIFO answering ack one cycle after enable:
  - `f_wr_en` pulses once, with `f_din`=0xA5A5A5A5.
  - `wr_done`=01 pulses exactly 3 cycles after the request cycle.
- Both writers held high continuously, with each client deasserting after its done and re-asserting one cycle later:
  - Grants alternate 0,1,0,1.
  - `f_wr_en` and `f_rd_en` are never high together.
- `wr_req`=01 and `rd_req`=10 together with the FIFO non-empty and non-full: write is granted first (`last_op` reset=read), then the read on the next arbitration. The read's `rd_data` equals `f_dout` (0x12345678) together with `rd_done`=10.
- `f_full`=1 with `wr_req`=11: no `f_wr_en` is issued and `busy` stays 0. Dropping `f_full` → a grant to writer 0.
- FIFO never responds, `TIMEOUT`=4: `rd_fail` pulses 6 cycles after the request cycle. If `f_rd_ack` and `f_rd_err` arrive in the same cycle: `rd_fail`, not `rd_done`.
- Assert `reset` during WAIT: all outputs are 0 immediately. No done/fail pulse follows, and the next request is granted normally.
